// File: rtl/ssd_scan_driver_pkg.sv
// Shared types and the hex-to-segment table for the seven-segment scan driver.
// The optional dimming feature is enabled by defining SSD_DIM_EN.
package ssd_scan_pkg;

   typedef enum logic {
      BLANK = 1'b0,
      ON    = 1'b1
   } slot_phase_e;

   typedef struct packed {
      logic       en;
      logic [3:0] val;
   } digit_t;

   // Active-high {g,f,e,d,c,b,a}, indexed by nibble value 0..F.
   localparam logic [6:0] HEX_SEG [16] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
      7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
      7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
   };

endpackage

// File: rtl/ssd_scan_driver_hex7seg.sv
// Combinational nibble to active-high seven-segment decoder.
module hex7seg
   import ssd_scan_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Table lookup of the segment pattern.
   always_comb begin
      seg = HEX_SEG[nibble];
   end

endmodule

// File: rtl/ssd_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with per-frame input snapshot
// and per-slot dead time. Define SSD_DIM_EN to add the bright_i dimming input.
module ssd_scan_driver
   import ssd_scan_pkg::*;
#(
   parameter int SLOT_CYCLES  = 100000,
   parameter int BLANK_CYCLES = 1000,
   parameter int ACTIVE_LOW   = 1
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       digit0_en_i,
   input  logic [3:0] digit0_i,
   input  logic       digit1_en_i,
   input  logic [3:0] digit1_i,
   input  logic       digit2_en_i,
   input  logic [3:0] digit2_i,
   input  logic       digit3_en_i,
   input  logic [3:0] digit3_i,
`ifdef SSD_DIM_EN
   input  logic [1:0] bright_i,
`endif
   output logic [3:0] anodes_o,
   output logic [6:0] segments_o,
   output logic       dp_o,
   output logic       frame_o
);

   localparam int          CW       = $clog2(SLOT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(SLOT_CYCLES - 1);
   localparam int unsigned ON_SPAN  = SLOT_CYCLES - BLANK_CYCLES;
   localparam int unsigned BLANK_U  = BLANK_CYCLES;
   localparam logic        POL      = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      idx_q, idx_d;
   digit_t [3:0]    snap_q, snap_d;
   slot_phase_e     phase_q, phase_d;
   logic [1:0]      bright_q, bright_d;
   logic [3:0]      anodes_q, anodes_d;
   logic [6:0]      segments_q, segments_d;
   logic            dp_q;
   logic            frame_q, frame_d;
   digit_t          sel_d;
   logic [6:0]      seg_hi;
   int unsigned     on_len;
   int unsigned     cnt_ext;

   hex7seg u_hex7seg (
      .nibble (sel_d.val),
      .seg    (seg_hi)
   );

   // Next counters, snapshot, slot phase and output pattern for the coming cycle.
   always_comb begin
      cnt_d    = cnt_q + CW'(1);
      idx_d    = idx_q;
      snap_d   = snap_q;
      bright_d = bright_q;
      if (cnt_q == CNT_LAST) begin
         cnt_d = '0;
         idx_d = idx_q + 2'd1;
         if (idx_q == 2'd3) begin
            snap_d[0] = '{en: digit0_en_i, val: digit0_i};
            snap_d[1] = '{en: digit1_en_i, val: digit1_i};
            snap_d[2] = '{en: digit2_en_i, val: digit2_i};
            snap_d[3] = '{en: digit3_en_i, val: digit3_i};
`ifdef SSD_DIM_EN
            bright_d  = bright_i;
`endif
         end else begin
            snap_d = snap_q;
         end
      end else begin
         idx_d = idx_q;
      end

`ifdef SSD_DIM_EN
      on_len = (ON_SPAN * (32'(bright_d) + 32'd1)) >> 2;
`else
      on_len = ON_SPAN;
`endif
      cnt_ext = 32'(cnt_d);
      phase_d = ((cnt_ext >= BLANK_U) && (cnt_ext < BLANK_U + on_len)) ? ON : BLANK;

      sel_d = snap_d[idx_d];
      if ((phase_d == ON) && sel_d.en) begin
         anodes_d   = (4'b0001 << idx_d) ^ {4{POL}};
         segments_d = seg_hi ^ {7{POL}};
      end else begin
         anodes_d   = {4{POL}};
         segments_d = {7{POL}};
      end
      frame_d = (idx_d == 2'd3) && (cnt_d == CNT_LAST);
   end

   // State and output registers; outputs track the newly loaded (idx, cnt).
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q      <= '0;
         idx_q      <= 2'd0;
         snap_q     <= '0;
         bright_q   <= 2'd3;
         phase_q    <= BLANK;
         anodes_q   <= {4{POL}};
         segments_q <= {7{POL}};
         dp_q       <= POL;
         frame_q    <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         snap_q     <= snap_d;
         bright_q   <= bright_d;
         phase_q    <= phase_d;
         anodes_q   <= anodes_d;
         segments_q <= segments_d;
         dp_q       <= POL;
         frame_q    <= frame_d;
      end
   end

   assign anodes_o   = anodes_q;
   assign segments_o = segments_q;
   assign dp_o       = dp_q;
   assign frame_o    = frame_q;

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver: a time-based reference model predicts
// every output cycle, a negedge monitor compares. Honours SSD_DIM_EN if defined.
module tb_ssd_scan_driver;

   localparam int S     = 8;
   localparam int B     = 2;
   localparam int FRAME = 4 * S;

   logic       clk = 1'b0;
   logic       rst_i;
   logic       en [4];
   logic [3:0] val [4];
   logic [1:0] bright;
   logic [3:0] anodes_o;
   logic [6:0] segments_o;
   logic       dp_o;
   logic       frame_o;

   int n_tests = 0;
   int n_fail  = 0;
   logic [12:0] exp_q [$];
   bit started = 1'b0;

   // Reference model state: cycles since reset and the captured frame inputs.
   int         m_t = 0;
   logic       m_en [4];
   logic [3:0] m_val [4];
   int         m_br = 3;

   logic [6:0] seg_tbl [16] = '{
      7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
      7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
      7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
      7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
   };

   always #5 clk = ~clk;

   ssd_scan_driver #(
      .SLOT_CYCLES  (S),
      .BLANK_CYCLES (B),
      .ACTIVE_LOW   (1)
   ) dut (
      .clk_i       (clk),
      .rst_i       (rst_i),
      .digit0_en_i (en[0]),
      .digit0_i    (val[0]),
      .digit1_en_i (en[1]),
      .digit1_i    (val[1]),
      .digit2_en_i (en[2]),
      .digit2_i    (val[2]),
      .digit3_en_i (en[3]),
      .digit3_i    (val[3]),
`ifdef SSD_DIM_EN
      .bright_i    (bright),
`endif
      .anodes_o    (anodes_o),
      .segments_o  (segments_o),
      .dp_o        (dp_o),
      .frame_o     (frame_o)
   );

   // Model: advance time at each edge and push the predicted output word.
   initial begin
      for (int k = 0; k < 4; k++) begin
         m_en[k]  = 1'b0;
         m_val[k] = 4'd0;
      end
      forever begin
         @(posedge clk);
         if (rst_i) begin
            m_t = 0;
            m_br = 3;
            for (int k = 0; k < 4; k++) begin
               m_en[k]  = 1'b0;
               m_val[k] = 4'd0;
            end
         end else begin
            if (m_t % FRAME == FRAME - 1) begin
               for (int k = 0; k < 4; k++) begin
                  m_en[k]  = en[k];
                  m_val[k] = val[k];
               end
`ifdef SSD_DIM_EN
               m_br = int'(bright);
`endif
            end
            m_t++;
         end
         begin
            int slot, c, on_len;
            logic lit;
            logic [3:0] an;
            logic [6:0] sg;
            slot = (m_t / S) % 4;
            c    = m_t % S;
`ifdef SSD_DIM_EN
            on_len = ((S - B) * (m_br + 1)) / 4;
`else
            on_len = S - B;
`endif
            lit = (c >= B) && (c < B + on_len) && m_en[slot];
            an  = lit ? ~(4'b0001 << slot) : 4'hF;
            sg  = lit ? ~seg_tbl[m_val[slot]] : 7'h7F;
            exp_q.push_back({an, sg, 1'b1, (slot == 3 && c == S - 1)});
            started = 1'b1;
         end
      end
   end

   // Monitor: compare each output cycle against the oldest prediction.
   initial begin
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            logic [12:0] e, a;
            e = exp_q.pop_front();
            a = {anodes_o, segments_o, dp_o, frame_o};
            n_tests++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL out t=%0d got an=%b seg=%b dp=%b fr=%b exp an=%b seg=%b dp=%b fr=%b",
                        m_t, a[12:9], a[8:2], a[1], a[0], e[12:9], e[8:2], e[1], e[0]);
            end
         end else if (started) begin
            n_tests++;
            n_fail++;
            $display("FAIL queue empty at t=%0d", m_t);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic set_all(input logic e, input logic [3:0] v0, input logic [3:0] v1,
                          input logic [3:0] v2, input logic [3:0] v3);
      for (int k = 0; k < 4; k++) en[k] = e;
      val[0] = v0; val[1] = v1; val[2] = v2; val[3] = v3;
   endtask

   initial begin
      rst_i  = 1'b1;
      bright = 2'd3;
      set_all(1'b1, 4'd0, 4'd1, 4'd2, 4'd3);
      cyc(3);
      rst_i = 1'b0;
      cyc(2 * FRAME + 10);

      // Disabled digit 2, 'A' on digit 3.
      en[2]  = 1'b0;
      val[3] = 4'hA;
      cyc(2 * FRAME);

      // Mid-frame change of digit 0 from 8 to F.
      val[0] = 4'h8;
      cyc(FRAME + 5);
      val[0] = 4'hF;
      cyc(2 * FRAME);

`ifdef SSD_DIM_EN
      bright = 2'd0;
      cyc(2 * FRAME);
      bright = 2'd3;
      cyc(FRAME);
`endif

      // One-cycle reset during the ON phase of slot 2.
      begin
         int guard = 0;
         while (((m_t % FRAME) != 2 * S + B + 1) && guard < 4 * FRAME) begin
            cyc(1);
            guard++;
         end
         if (guard >= 4 * FRAME) begin
            n_tests++;
            n_fail++;
            $display("FAIL slot2_wait guard=%0d expected < %0d", guard, 4 * FRAME);
         end
      end
      rst_i = 1'b1;
      cyc(1);
      rst_i = 1'b0;
      cyc(2 * FRAME + 4);

      // Randomized inputs with occasional reset pulses.
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 5) == 0) begin
            int k;
            k = $urandom_range(0, 3);
            en[k]  = 1'($urandom_range(0, 3) != 0);
            val[k] = 4'($urandom_range(0, 15));
         end
         if ($urandom_range(0, 15) == 0) bright = 2'($urandom_range(0, 3));
         rst_i = ($urandom_range(0, 299) == 0);
         cyc(1);
      end
      rst_i = 1'b0;
      cyc(3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
